// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline bundle: decoded ID-slot fields and flush in, EX-slot copies and load-use stall out.
interface id_ex_stage_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
);
   logic             id_valid;
   logic [7:0]       id_ctrl;
   logic [3:0]       id_funct;
   logic [XLEN-1:0]  id_pc;
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic [4:0]       id_rd;
   logic [XLEN-1:0]  id_rs1_data;
   logic [XLEN-1:0]  id_rs2_data;
   logic [XLEN-1:0]  id_imm;
   logic             flush;

   logic             ex_valid;
   logic [7:0]       ex_ctrl;
   logic [3:0]       ex_funct;
   logic [XLEN-1:0]  ex_pc;
   logic [XLEN-1:0]  ex_rs1_data;
   logic [XLEN-1:0]  ex_rs2_data;
   logic [XLEN-1:0]  ex_imm;
   logic [4:0]       ex_rs1;
   logic [4:0]       ex_rs2;
   logic [4:0]       ex_rd;
   logic             stall;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_valid, id_ctrl, id_funct, id_pc, id_rs1, id_rs2, id_rd,
             id_rs1_data, id_rs2_data, id_imm, flush,
      input  ex_valid, ex_ctrl, ex_funct, ex_pc, ex_rs1_data, ex_rs2_data,
             ex_imm, ex_rs1, ex_rs2, ex_rd, stall, stall_count
   );

   modport slave (
      input  id_valid, id_ctrl, id_funct, id_pc, id_rs1, id_rs2, id_rd,
             id_rs1_data, id_rs2_data, id_imm, flush,
      output ex_valid, ex_ctrl, ex_funct, ex_pc, ex_rs1_data, ex_rs2_data,
             ex_imm, ex_rs1, ex_rs2, ex_rd, stall, stall_count
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and a saturating stall counter.
module id_ex_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input logic          clk,
   input logic          reset,
   id_ex_stage_if.slave bus
);
   // id_ctrl bit positions
   localparam int unsigned C_REGWRITE = 0;
   localparam int unsigned C_ALUSRC   = 1;
   localparam int unsigned C_MEMWRITE = 2;
   localparam int unsigned C_MEMTOREG = 3;
   localparam int unsigned C_MEMREAD  = 4;
   localparam int unsigned C_BRANCH   = 5;

   logic             ex_valid_q,    ex_valid_d;
   logic [7:0]       ex_ctrl_q,     ex_ctrl_d;
   logic [3:0]       ex_funct_q,    ex_funct_d;
   logic [XLEN-1:0]  ex_pc_q,       ex_pc_d;
   logic [XLEN-1:0]  ex_rs1_data_q, ex_rs1_data_d;
   logic [XLEN-1:0]  ex_rs2_data_q, ex_rs2_data_d;
   logic [XLEN-1:0]  ex_imm_q,      ex_imm_d;
   logic [4:0]       ex_rs1_q,      ex_rs1_d;
   logic [4:0]       ex_rs2_q,      ex_rs2_d;
   logic [4:0]       ex_rd_q,       ex_rd_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;

   logic rs1_use, rs2_use, hazard, load;

   // Load in EX whose destination is a source the ID instruction actually reads
   always_comb begin
      rs1_use = bus.id_valid & (bus.id_ctrl[C_REGWRITE] | bus.id_ctrl[C_MEMWRITE] |
                                bus.id_ctrl[C_BRANCH]);
      rs2_use = bus.id_valid & (~bus.id_ctrl[C_ALUSRC] | bus.id_ctrl[C_MEMWRITE]);
      hazard  = ex_valid_q & ex_ctrl_q[C_MEMREAD] & (ex_rd_q != 5'd0) &
                ((rs1_use & (bus.id_rs1 == ex_rd_q)) | (rs2_use & (bus.id_rs2 == ex_rd_q)));
   end

   assign bus.stall = hazard & ~bus.flush & ~reset;
   assign load      = bus.id_valid & ~bus.flush & ~hazard;

   // Next EX slot: bubble unless a clean load; count only stall-induced bubbles
   always_comb begin
      ex_valid_d    = 1'b0;
      ex_ctrl_d     = '0;
      ex_funct_d    = '0;
      ex_pc_d       = '0;
      ex_rs1_data_d = '0;
      ex_rs2_data_d = '0;
      ex_imm_d      = '0;
      ex_rs1_d      = '0;
      ex_rs2_d      = '0;
      ex_rd_d       = '0;
      stall_count_d = stall_count_q;
      if (bus.stall) begin
         if (stall_count_q != '1) stall_count_d = stall_count_q + CNT_W'(1);
      end else if (load) begin
         ex_valid_d              = 1'b1;
         ex_ctrl_d               = bus.id_ctrl;
         // MemtoReg is don't-care from the decoder when nothing is written back
         ex_ctrl_d[C_MEMTOREG]   = bus.id_ctrl[C_MEMTOREG] & bus.id_ctrl[C_REGWRITE];
         ex_funct_d              = bus.id_funct;
         ex_pc_d                 = bus.id_pc;
         ex_rs1_data_d           = bus.id_rs1_data;
         ex_rs2_data_d           = bus.id_rs2_data;
         ex_imm_d                = bus.id_imm;
         ex_rs1_d                = bus.id_rs1;
         ex_rs2_d                = bus.id_rs2;
         ex_rd_d                 = bus.id_rd;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid_q    <= 1'b0;
         ex_ctrl_q     <= '0;
         ex_funct_q    <= '0;
         ex_pc_q       <= '0;
         ex_rs1_data_q <= '0;
         ex_rs2_data_q <= '0;
         ex_imm_q      <= '0;
         ex_rs1_q      <= '0;
         ex_rs2_q      <= '0;
         ex_rd_q       <= '0;
         stall_count_q <= '0;
      end else begin
         ex_valid_q    <= ex_valid_d;
         ex_ctrl_q     <= ex_ctrl_d;
         ex_funct_q    <= ex_funct_d;
         ex_pc_q       <= ex_pc_d;
         ex_rs1_data_q <= ex_rs1_data_d;
         ex_rs2_data_q <= ex_rs2_data_d;
         ex_imm_q      <= ex_imm_d;
         ex_rs1_q      <= ex_rs1_d;
         ex_rs2_q      <= ex_rs2_d;
         ex_rd_q       <= ex_rd_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign bus.ex_valid    = ex_valid_q;
   assign bus.ex_ctrl     = ex_ctrl_q;
   assign bus.ex_funct    = ex_funct_q;
   assign bus.ex_pc       = ex_pc_q;
   assign bus.ex_rs1_data = ex_rs1_data_q;
   assign bus.ex_rs2_data = ex_rs2_data_q;
   assign bus.ex_imm      = ex_imm_q;
   assign bus.ex_rs1      = ex_rs1_q;
   assign bus.ex_rs2      = ex_rs2_q;
   assign bus.ex_rd       = ex_rd_q;
   assign bus.stall_count = stall_count_q;
endmodule
